// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder over a constant ROM region and a RAM region,
// answering a fixed LATENCY cycles after acceptance with a ready/valid response channel.
module data_memory_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int ROM_DEPTH  = 256,
  parameter int RAM_DEPTH  = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error
);

  localparam int         OFF_W    = ADDR_WIDTH - 1;
  localparam int         RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Captured request (stage p0) and the registered response (stage p1).
  logic                  write_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  error_p1;

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

  logic                  accept;
  logic                  resolve;
  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [OFF_W-1:0]      cur_off;
  logic                  cur_err;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] load_data;

  function automatic logic addr_error(input logic wr, input logic [ADDR_WIDTH-1:0] a);
    int off;
    off = int'(a[OFF_W-1:0]);
    if (a[ADDR_WIDTH-1]) return (off >= RAM_DEPTH);
    return wr || (off >= ROM_DEPTH);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [OFF_W-1:0] off);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[OFF_W-1:0] = off;
    return w;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the response resolves on the accepting edge, before p0 is loaded,
  // so the live request inputs stand in for the captured copy while in IDLE.
  always_comb begin
    cur_write = write_p0;
    cur_addr  = addr_p0;
    cur_wdata = wdata_p0;
    if (state == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign accept    = req_valid && (state == IDLE);
  assign resolve   = (state != RESP) && (state_nxt == RESP);
  assign cur_off   = cur_addr[OFF_W-1:0];
  assign cur_err   = addr_error(cur_write, cur_addr);
  assign ram_we    = resolve && !rst && cur_write && !cur_err;
  assign load_data = (cur_err || cur_write) ? '0 :
                     (cur_addr[ADDR_WIDTH-1] ? ram[cur_off[RAM_AW-1:0]] : rom_word(cur_off));

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rdata_p1 <= '0;
      error_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (resolve) begin
        rdata_p1 <= load_data;
        error_p1 <= cur_err;
      end else if (resp_valid && resp_ready) begin
        rdata_p1 <= '0;
        error_p1 <= 1'b0;
      end
    end
  end

  // Request capture and RAM storage carry no reset; a store commits only on the
  // edge that enters RESP, so a reset while waiting drops it.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
    if (ram_we) ram[cur_off[RAM_AW-1:0]] <= cur_wdata;
  end

  assign resp_rdata = rdata_p1;
  assign resp_error = error_p1;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: three instances (LATENCY 2/1/4, reduced
// depths on two) checked every cycle against a transaction-level reference model.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [8:0]  req_addr  [3];
  logic [63:0] req_wdata [3];
  logic        resp_valid[3];
  logic        resp_ready[3];
  logic [63:0] resp_rdata[3];
  logic        resp_error[3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .ROM_DEPTH(256), .RAM_DEPTH(200), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

  data_memory_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .ROM_DEPTH(100), .RAM_DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

  data_memory_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .ROM_DEPTH(256), .RAM_DEPTH(256), .LATENCY(4)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

  function automatic int lat_of(int i);
    case (i)
      0: return 2;
      1: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int rom_d(int i);
    return (i == 1) ? 100 : 256;
  endfunction

  function automatic int ram_d(int i);
    return (i == 0) ? 200 : 256;
  endfunction

  task automatic check(string nm, int i, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Reference model: a request is outstanding from acceptance until its response is
  // taken; it becomes visible LATENCY edges after acceptance (counting the accepting edge).
  bit          m_busy [3];
  bit          m_vis  [3];
  bit          m_rchk [3];
  int          m_acc  [3];
  logic        m_w    [3];
  logic [8:0]  m_a    [3];
  logic [63:0] m_d    [3];
  logic [63:0] m_rdata[3];
  logic        m_err  [3];
  logic [63:0] sram   [3][256];
  bit          known  [3][256];

  task automatic model_resolve(int i);
    int off;
    bit is_ram;
    off    = int'(m_a[i][7:0]);
    is_ram = m_a[i][8];
    m_vis[i]   = 1'b1;
    m_rchk[i]  = 1'b1;
    m_rdata[i] = '0;
    if ((is_ram && off >= ram_d(i)) || (!is_ram && (m_w[i] || off >= rom_d(i)))) begin
      m_err[i] = 1'b1;
    end else begin
      m_err[i] = 1'b0;
      if (m_w[i]) begin
        sram[i][off]  = m_d[i];
        known[i][off] = 1'b1;
      end else if (is_ram) begin
        m_rdata[i] = sram[i][off];
        m_rchk[i]  = known[i][off];
      end else begin
        m_rdata[i] = 64'(off);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_vis[i]  = 1'b0;
      end else begin
        if (m_vis[i]) begin
          if (resp_ready[i]) begin
            m_busy[i] = 1'b0;
            m_vis[i]  = 1'b0;
          end
        end else if (!m_busy[i] && req_valid[i]) begin
          m_busy[i] = 1'b1;
          m_acc[i]  = cyc;
          m_w[i]    = req_write[i];
          m_a[i]    = req_addr[i];
          m_d[i]    = req_wdata[i];
        end
        if (m_busy[i] && !m_vis[i] && cyc == m_acc[i] + lat_of(i) - 1) model_resolve(i);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        check("req_ready", i, 64'(req_ready[i]), 64'(!m_busy[i]));
        check("resp_valid", i, 64'(resp_valid[i]), 64'(m_vis[i]));
        if (m_vis[i]) begin
          check("resp_error", i, 64'(resp_error[i]), 64'(m_err[i]));
          if (m_rchk[i]) check("resp_rdata", i, resp_rdata[i], m_rdata[i]);
        end
      end
    end
  end

  // Returns at posedge+2 just after the accepting edge, with c = that edge's cycle number.
  task automatic wait_accept(int i, output int c);
    logic r;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      r = req_ready[i];
      @(posedge clk);
      #2;
      if (r) begin
        c = cyc;
        return;
      end
    end
    c = -1;
    check("accept_timeout", i, 64'(1), 64'(0));
  endtask

  task automatic run_req(int i, logic w, logic [8:0] a, logic [63:0] d, int hold,
                         output logic [63:0] rd, output logic er, output int latency);
    int  ac;
    bit  seen;
    req_valid[i]  = 1'b1;
    req_write[i]  = w;
    req_addr[i]   = a;
    req_wdata[i]  = d;
    resp_ready[i] = (hold == 0);
    wait_accept(i, ac);
    req_valid[i] = 1'b0;
    req_write[i] = ~w;
    req_addr[i]  = ~a;
    req_wdata[i] = ~d;
    seen    = 1'b0;
    rd      = 'x;
    er      = 1'bx;
    latency = -1;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      if (resp_valid[i]) seen = 1'b1;
    end
    if (!seen) begin
      check("resp_timeout", i, 64'(1), 64'(0));
      @(posedge clk);
      #2;
      return;
    end
    latency = cyc - ac + 1;
    rd      = resp_rdata[i];
    er      = resp_error[i];
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2;
      resp_ready[i] = 1'b1;
    end
    @(posedge clk);
    #2;
    resp_ready[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          a1, a2;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 0, 64'(req_ready[0]), 64'(1));
    check("rst_resp_valid", 0, 64'(resp_valid[0]), 64'(0));
    check("rst_rdata", 0, resp_rdata[0], 64'h0);
    check("rst_error", 0, 64'(resp_error[0]), 64'(0));
    @(posedge clk);
    #2;

    // ROM load, LATENCY=2
    run_req(0, 1'b0, 9'h005, 64'h0, 0, rd, er, lat);
    check("rom5_lat", 0, 64'(lat), 64'(2));
    check("rom5_rdata", 0, rd, 64'h5);
    check("rom5_err", 0, 64'(er), 64'(0));

    // RAM store then load back
    run_req(0, 1'b1, 9'h103, 64'hDEADBEEF_CAFEF00D, 0, rd, er, lat);
    check("st103_err", 0, 64'(er), 64'(0));
    check("st103_rdata", 0, rd, 64'h0);
    run_req(0, 1'b0, 9'h103, 64'h0, 0, rd, er, lat);
    check("ld103_rdata", 0, rd, 64'hDEADBEEF_CAFEF00D);

    // ROM store is rejected, ROM unchanged
    run_req(0, 1'b1, 9'h010, 64'h0AA, 0, rd, er, lat);
    check("st_rom_err", 0, 64'(er), 64'(1));
    check("st_rom_rdata", 0, rd, 64'h0);
    run_req(0, 1'b0, 9'h010, 64'h0, 0, rd, er, lat);
    check("ld_rom10", 0, rd, 64'h10);

    // Response held while resp_ready is low
    run_req(0, 1'b0, 9'h103, 64'h0, 5, rd, er, lat);
    check("hold_rdata", 0, rd, 64'hDEADBEEF_CAFEF00D);

    // RAM region out of range on a 200-word RAM
    run_req(0, 1'b1, 9'h1C8, 64'h1234, 0, rd, er, lat);
    check("ram_oor_err", 0, 64'(er), 64'(1));
    run_req(0, 1'b1, 9'h1C7, 64'h5555_AAAA_0000_FFFF, 0, rd, er, lat);
    run_req(0, 1'b0, 9'h1C7, 64'h0, 0, rd, er, lat);
    check("ram_last_word", 0, rd, 64'h5555_AAAA_0000_FFFF);

    // Reset during WAIT drops the store
    run_req(0, 1'b1, 9'h104, 64'h1111, 0, rd, er, lat);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 9'h104;
    req_wdata[0] = 64'h2222;
    wait_accept(0, a1);
    rst          = 1'b1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 0, 64'(req_ready[0]), 64'(1));
    check("abort_resp_valid", 0, 64'(resp_valid[0]), 64'(0));
    check("abort_rdata", 0, resp_rdata[0], 64'h0);
    check("abort_error", 0, 64'(resp_error[0]), 64'(0));
    @(posedge clk);
    #2;
    run_req(0, 1'b0, 9'h104, 64'h0, 0, rd, er, lat);
    check("abort_kept", 0, rd, 64'h1111);

    // Back-to-back loads with req_valid held, LATENCY=1
    req_valid[1]  = 1'b1;
    req_write[1]  = 1'b0;
    req_addr[1]   = 9'h001;
    resp_ready[1] = 1'b1;
    wait_accept(1, a1);
    req_addr[1] = 9'h002;
    @(negedge clk);
    check("b2b_first_rdata", 1, resp_rdata[1], 64'h1);
    wait_accept(1, a2);
    req_valid[1] = 1'b0;
    check("b2b_spacing", 1, 64'(a2 - a1), 64'(2));
    @(negedge clk);
    check("b2b_second_rdata", 1, resp_rdata[1], 64'h2);
    @(posedge clk);
    #2 resp_ready[1] = 1'b0;

    // ROM depth boundary on a 100-word ROM; store followed by load of same word
    run_req(1, 1'b0, 9'h063, 64'h0, 0, rd, er, lat);
    check("rom_last", 1, rd, 64'h63);
    run_req(1, 1'b0, 9'h064, 64'h0, 0, rd, er, lat);
    check("rom_oor_err", 1, 64'(er), 64'(1));
    run_req(1, 1'b1, 9'h1FF, 64'hFEED, 0, rd, er, lat);
    run_req(1, 1'b0, 9'h1FF, 64'h0, 0, rd, er, lat);
    check("l1_raw", 1, rd, 64'hFEED);

    // LATENCY=4 exercises the countdown
    run_req(2, 1'b0, 9'h005, 64'h0, 0, rd, er, lat);
    check("l4_lat", 2, 64'(lat), 64'(4));
    check("l4_rdata", 2, rd, 64'h5);
    run_req(2, 1'b1, 9'h1AB, 64'h0123_4567_89AB_CDEF, 2, rd, er, lat);
    run_req(2, 1'b0, 9'h1AB, 64'h0, 0, rd, er, lat);
    check("l4_raw", 2, rd, 64'h0123_4567_89AB_CDEF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning width of the data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning word address width; MSB selects region (0 = ROM, 1 = RAM).
REQ-003 SHALL have parameter ROM_DEPTH, default 256, meaning number of ROM words.
REQ-004 SHALL have parameter RAM_DEPTH, default 256, meaning number of RAM words.
REQ-005 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid; legal range 1..15.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port req_valid  input  1  initiator presents a request.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request.
REQ-010 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  word address.
REQ-012 SHALL have port req_wdata  input  DATA_WIDTH  store data.
REQ-013 SHALL have port resp_valid  output  1  response available.
REQ-014 SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-015 SHALL have port resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
REQ-016 SHALL have port resp_error  output  1  store to ROM or address beyond region depth.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding request maximum.
REQ-018 SHALL drive req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-019 SHALL accept a request on a rising edge where req_valid && req_ready, capturing req_write, req_addr, req_wdata.
REQ-020 SHALL, on acceptance, go IDLE->RESP if LATENCY = 1, else IDLE->WAIT loading a 4-bit counter with LATENCY-1.
REQ-021 SHALL decrement the counter each WAIT cycle and go WAIT->RESP when it reaches 1, so resp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-022 SHALL hold resp_valid, resp_rdata, resp_error stable in RESP until resp_ready; go RESP->IDLE on the edge where resp_valid && resp_ready.
REQ-023 SHALL not accept a new request in the same cycle a response completes (req_ready low in RESP); next acceptance earliest one cycle after RESP->IDLE.
REQ-024 SHALL decode region by addr[ADDR_WIDTH-1] and offset by addr[ADDR_WIDTH-2:0]; offset >= region depth SHALL set resp_error.
REQ-025 SHALL, for a valid load, return the addressed word; ROM word i SHALL equal i zero-extended to DATA_WIDTH.
REQ-026 SHALL, for a valid RAM store, write req_wdata exactly once, committed before resp_valid rises; resp_rdata = 0, resp_error = 0.
REQ-027 SHALL, for a ROM store or out-of-range access, leave all memory unchanged, resp_rdata = 0, resp_error = 1.
REQ-028 SHALL ignore req_* inputs outside the accepting edge; changes in WAIT/RESP SHALL not affect the pending response.
REQ-029 SHALL make a load to a RAM word written by the immediately preceding request return the new data.

Reset
REQ-030 SHALL, while rst is high at a rising edge, enter IDLE, clear counter, drive req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0.
REQ-031 SHALL abort any in-flight request on reset; a store in WAIT whose write has not committed SHALL be dropped, no response issued.
REQ-032 SHALL leave RAM contents unaffected by reset; power-up RAM contents are undefined.

Verification
REQ-033 Load addr 0x005 (ROM), LATENCY=2, resp_ready=1 -> resp_valid exactly 2 cycles after acceptance, rdata=0x5, error=0.
REQ-034 Store 0xDEADBEEF_CAFEF00D to 0x103, then load 0x103 -> store resp error=0 rdata=0; load rdata=0xDEADBEEF_CAFEF00D.
REQ-035 Store 0x0AA to 0x010 (ROM) -> error=1; subsequent load 0x010 returns 0x10.
REQ-036 Load 0x103 with resp_ready low 5 cycles -> resp_valid, rdata held 5 cycles, req_ready=0 throughout, IDLE one cycle after handshake.
REQ-037 Accept store to 0x104, assert rst during WAIT -> no response, req_ready=1 after reset, prior content of 0x104 unchanged.
REQ-038 Back-to-back loads 0x001, 0x002 with req_valid held high, LATENCY=1 -> acceptances separated by 2 cycles, rdata 0x1 then 0x2.
